// File: rtl/hamm_stream_if.sv
// Codeword-in / packed-word-out stream bundle for the Hamming(7,4) decoder.
//   cw_valid/cw_ready/cw_in         : codeword handshake, one codeword per accept
//   word_valid/word_ready/word_data : packed corrected word handshake
//   err_flags                       : per-slot "syndrome was nonzero" flags
//   corr_cnt                        : saturating count of corrected codewords
// master = source/consumer side, slave = decoder side.
interface hamm_stream_if #(
  parameter int unsigned NCW   = 4,
  parameter int unsigned CNT_W = 8
);
  logic               cw_valid;
  logic               cw_ready;
  logic [6:0]         cw_in;
  logic               word_valid;
  logic               word_ready;
  logic [4*NCW-1:0]   word_data;
  logic [NCW-1:0]     err_flags;
  logic [CNT_W-1:0]   corr_cnt;

  modport master (
    output cw_valid, cw_in, word_ready,
    input  cw_ready, word_valid, word_data, err_flags, corr_cnt
  );

  modport slave (
    input  cw_valid, cw_in, word_ready,
    output cw_ready, word_valid, word_data, err_flags, corr_cnt
  );
endinterface

// File: rtl/hamm_stream_decoder.sv
// Hamming(7,4) stream decoder: corrects single-bit errors per codeword, packs NCW
// corrected nibbles into one word and hands it out with valid/ready.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : hamm_stream_if.slave (codeword in, packed word out, flags, counter)
// Outputs are registers or decodes of the state register only.
module hamm_stream_decoder #(
  parameter int unsigned NCW   = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  hamm_stream_if.slave bus
);
  localparam int unsigned W     = 4 * NCW;
  localparam int unsigned IDX_W = (NCW > 1) ? $clog2(NCW) : 1;

  typedef enum logic [0:0] {COLLECT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   slot_q, slot_d;
  logic [W-1:0]       data_q, data_d;
  logic [NCW-1:0]     flags_q, flags_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [2:0]         syn;
  logic [6:0]         fixed;
  logic [3:0]         nib;

  // Syndrome and single-bit correction; syndrome value s points at position s.
  always_comb begin
    syn[0] = bus.cw_in[0] ^ bus.cw_in[2] ^ bus.cw_in[4] ^ bus.cw_in[6];
    syn[1] = bus.cw_in[1] ^ bus.cw_in[2] ^ bus.cw_in[5] ^ bus.cw_in[6];
    syn[2] = bus.cw_in[3] ^ bus.cw_in[4] ^ bus.cw_in[5] ^ bus.cw_in[6];
    for (int i = 0; i < 7; i++) begin
      fixed[i] = bus.cw_in[i] ^ (syn == 3'(i + 1));
    end
    nib = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      slot_q  <= '0;
      data_q  <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    data_d  = data_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    case (state_q)
      COLLECT: begin
        if (bus.cw_valid) begin
          data_d[{slot_q, 2'b00} +: 4] = nib;
          flags_d[slot_q]              = |syn;
          if ((|syn) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (slot_q == IDX_W'(NCW - 1)) begin
            slot_d  = '0;
            state_d = HOLD;
          end else begin
            slot_d = slot_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.word_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign bus.cw_ready   = (state_q == COLLECT);
  assign bus.word_valid = (state_q == HOLD);
  assign bus.word_data  = data_q;
  assign bus.err_flags  = flags_q;
  assign bus.corr_cnt   = cnt_q;
endmodule
